// File: rtl/ex_stage.sv
// Execute stage: combinational ALU with a same-cycle forwarding path, followed by
// the EX/MEM pipeline register with stall/flush and overflow-to-exception handling.

module ex_alu #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ALU_OP_W = 4
) (
  input  logic [ALU_OP_W-1:0] op,
  input  logic [DATA_W-1:0]   in_0,
  input  logic [DATA_W-1:0]   in_1,
  output logic [DATA_W-1:0]   out,
  output logic                of
);
  localparam int unsigned SHAMT_W = $clog2(DATA_W);
  localparam int unsigned MSB     = DATA_W - 1;

  localparam logic [ALU_OP_W-1:0] OP_AND  = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] OP_OR   = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] OP_XOR  = ALU_OP_W'(3);
  localparam logic [ALU_OP_W-1:0] OP_ADDS = ALU_OP_W'(4);
  localparam logic [ALU_OP_W-1:0] OP_ADDU = ALU_OP_W'(5);
  localparam logic [ALU_OP_W-1:0] OP_SUBS = ALU_OP_W'(6);
  localparam logic [ALU_OP_W-1:0] OP_SUBU = ALU_OP_W'(7);
  localparam logic [ALU_OP_W-1:0] OP_SHRL = ALU_OP_W'(8);
  localparam logic [ALU_OP_W-1:0] OP_SHLL = ALU_OP_W'(9);

  logic [DATA_W-1:0]  sum;
  logic [DATA_W-1:0]  diff;
  logic [SHAMT_W-1:0] shamt;
  logic               add_of;
  logic               sub_of;

  assign sum   = in_0 + in_1;
  assign diff  = in_0 - in_1;
  assign shamt = in_1[SHAMT_W-1:0];

  // Signed overflow: result sign differs from operand 0 when operand signs make that impossible
  assign add_of = (in_0[MSB] == in_1[MSB]) && (sum[MSB]  != in_0[MSB]);
  assign sub_of = (in_0[MSB] != in_1[MSB]) && (diff[MSB] != in_0[MSB]);

  always_comb begin
    out = in_0;
    of  = 1'b0;
    case (op)
      OP_AND:  out = in_0 & in_1;
      OP_OR:   out = in_0 | in_1;
      OP_XOR:  out = in_0 ^ in_1;
      OP_ADDS: begin out = sum;  of = add_of; end
      OP_ADDU: out = sum;
      OP_SUBS: begin out = diff; of = sub_of; end
      OP_SUBU: out = diff;
      OP_SHRL: out = in_0 >> shamt;
      OP_SHLL: out = in_0 << shamt;
      default: out = in_0;
    endcase
  end
endmodule

module ex_stage #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 30,
  parameter int unsigned ALU_OP_W   = 4,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned MEM_OP_W   = 2,
  parameter int unsigned CTRL_OP_W  = 2,
  parameter int unsigned EXP_W      = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [ADDR_W-1:0]     id_pc,
  input  logic                  id_en,
  input  logic [ALU_OP_W-1:0]   id_alu_op,
  input  logic [DATA_W-1:0]     id_alu_in_0,
  input  logic [DATA_W-1:0]     id_alu_in_1,
  input  logic                  id_br_flag,
  input  logic [MEM_OP_W-1:0]   id_mem_op,
  input  logic [DATA_W-1:0]     id_mem_wr_data,
  input  logic [CTRL_OP_W-1:0]  id_ctrl_op,
  input  logic [REG_ADDR_W-1:0] id_dst_addr,
  input  logic                  id_gpr_we_,
  input  logic [EXP_W-1:0]      id_exp_code,
  output logic [DATA_W-1:0]     fwd_data,
  output logic [ADDR_W-1:0]     ex_pc,
  output logic                  ex_en,
  output logic                  ex_br_flag,
  output logic [MEM_OP_W-1:0]   ex_mem_op,
  output logic [DATA_W-1:0]     ex_mem_wr_data,
  output logic [CTRL_OP_W-1:0]  ex_ctrl_op,
  output logic [REG_ADDR_W-1:0] ex_dst_addr,
  output logic                  ex_gpr_we_,
  output logic [EXP_W-1:0]      ex_exp_code,
  output logic [DATA_W-1:0]     ex_out
);
  localparam logic [EXP_W-1:0] EXP_OVERFLOW = EXP_W'(3);

  logic [DATA_W-1:0]     alu_out;
  logic                  alu_of;

  logic [ADDR_W-1:0]     pc_d;
  logic                  en_d;
  logic                  br_flag_d;
  logic [MEM_OP_W-1:0]   mem_op_d;
  logic [DATA_W-1:0]     mem_wr_data_d;
  logic [CTRL_OP_W-1:0]  ctrl_op_d;
  logic [REG_ADDR_W-1:0] dst_addr_d;
  logic                  gpr_we_d;
  logic [EXP_W-1:0]      exp_code_d;
  logic [DATA_W-1:0]     out_d;

  ex_alu #(
    .DATA_W   (DATA_W),
    .ALU_OP_W (ALU_OP_W)
  ) u_alu (
    .op   (id_alu_op),
    .in_0 (id_alu_in_0),
    .in_1 (id_alu_in_1),
    .out  (alu_out),
    .of   (alu_of)
  );

  assign fwd_data = alu_out;

  // Next EX/MEM contents: bubble, faulting instruction (side effects killed) or normal load
  always_comb begin
    pc_d          = '0;
    en_d          = 1'b0;
    br_flag_d     = 1'b0;
    mem_op_d      = '0;
    mem_wr_data_d = '0;
    ctrl_op_d     = '0;
    dst_addr_d    = '0;
    gpr_we_d      = 1'b1;
    exp_code_d    = '0;
    out_d         = '0;
    if (!flush) begin
      pc_d = id_pc;
      if (id_en) begin
        en_d          = 1'b1;
        br_flag_d     = id_br_flag;
        mem_wr_data_d = id_mem_wr_data;
        dst_addr_d    = id_dst_addr;
        out_d         = alu_out;
        if (id_exp_code != '0) begin
          exp_code_d = id_exp_code;
        end else if (alu_of) begin
          exp_code_d = EXP_OVERFLOW;
        end else begin
          mem_op_d  = id_mem_op;
          ctrl_op_d = id_ctrl_op;
          gpr_we_d  = id_gpr_we_;
        end
      end
    end
  end

  // EX/MEM pipeline register; stall holds everything, overriding flush
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_pc          <= '0;
      ex_en          <= 1'b0;
      ex_br_flag     <= 1'b0;
      ex_mem_op      <= '0;
      ex_mem_wr_data <= '0;
      ex_ctrl_op     <= '0;
      ex_dst_addr    <= '0;
      ex_gpr_we_     <= 1'b1;
      ex_exp_code    <= '0;
      ex_out         <= '0;
    end else if (!stall) begin
      ex_pc          <= pc_d;
      ex_en          <= en_d;
      ex_br_flag     <= br_flag_d;
      ex_mem_op      <= mem_op_d;
      ex_mem_wr_data <= mem_wr_data_d;
      ex_ctrl_op     <= ctrl_op_d;
      ex_dst_addr    <= dst_addr_d;
      ex_gpr_we_     <= gpr_we_d;
      ex_exp_code    <= exp_code_d;
      ex_out         <= out_d;
    end
  end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage pipeline. Sits between the ID/EX pipeline register and the MEM stage.
- Instantiates the ALU, which is combinational. Exposes the ALU result as a same-cycle forwarding path.
- Latches the result and control fields into the EX/MEM pipeline register.
- Converts ALU signed overflow into a pipeline exception and suppresses the offending instruction's side effects.

Parameters:
- DATA_W, 32, word data width.
- ADDR_W, 30, word address (PC) width.
- ALU_OP_W, 4, ALU opcode width. Encoding: NOP=0, AND=1, OR=2, XOR=3, ADDS=4, ADDU=5, SUBS=6, SUBU=7, SHRL=8, SHLL=9.
- REG_ADDR_W, 5, GPR address width.
- MEM_OP_W, 2, memory opcode width. NOP=0, LDW=1, STW=2.
- CTRL_OP_W, 2, control opcode width. NOP=0.
- EXP_W, 3, exception code width. NO_EXP=0, OVERFLOW=3.

Ports:
- clk  in  1  clock; all registers update on the rising edge.
- reset  in  1  asynchronous reset, active-low.
- stall  in  1  hold the EX/MEM register.
- flush  in  1  convert the latched instruction into a bubble.
- id_pc  in  ADDR_W  PC of the instruction.
- id_en  in  1  instruction valid.
- id_alu_op  in  ALU_OP_W  ALU operation.
- id_alu_in_0  in  DATA_W  operand 0.
- id_alu_in_1  in  DATA_W  operand 1.
- id_br_flag  in  1  branch-taken flag, passed through.
- id_mem_op  in  MEM_OP_W  memory operation.
- id_mem_wr_data  in  DATA_W  store data.
- id_ctrl_op  in  CTRL_OP_W  control operation.
- id_dst_addr  in  REG_ADDR_W  GPR destination.
- id_gpr_we_  in  1  GPR write enable, active-low.
- id_exp_code  in  EXP_W  upstream exception code.
- fwd_data  out  DATA_W  combinational ALU result, for ID-stage forwarding.
- ex_pc  out  ADDR_W  registered.
- ex_en  out  1  registered.
- ex_br_flag  out  1  registered.
- ex_mem_op  out  MEM_OP_W  registered.
- ex_mem_wr_data  out  DATA_W  registered.
- ex_ctrl_op  out  CTRL_OP_W  registered.
- ex_dst_addr  out  REG_ADDR_W  registered.
- ex_gpr_we_  out  1  registered, active-low.
- ex_exp_code  out  EXP_W  registered.
- ex_out  out  DATA_W  registered ALU result.

Behaviour:
- ALU inputs: in_0=id_alu_in_0, in_1=id_alu_in_1, op=id_alu_op.
- fwd_data = ALU out, zero latency, independent of stall/flush.
- Shifts use in_1[4:0]. Add/sub wrap modulo 2^DATA_W. Unlisted ops output in_0.
- Overflow (of) is asserted only for ADDS/SUBS, per the signed rule: operands of like sign (add) or unlike sign (sub) producing a result of opposite sign to operand 0.
- Reset (reset=0, asynchronous): all registered outputs 0, except ex_gpr_we_=1. Holds while reset is low. Takes effect mid-instruction with no pending state.
- Update priority on each rising edge: reset > stall > flush > load.
- stall=1: every register holds, even if flush=1 in the same cycle.
- flush=1, stall=0: load a bubble.
  - ex_en=0, ex_br_flag=0, mem_op=NOP, ctrl_op=NOP, ex_gpr_we_=1, ex_exp_code=0.
  - ex_pc, ex_dst_addr, ex_out, ex_mem_wr_data = 0.
- Load: ex_pc, ex_en, ex_dst_addr, ex_mem_wr_data, ex_br_flag and ex_out latch their inputs. Remaining fields by case:
  - id_en=0: latch as a bubble (same as flush) but keep ex_pc.
  - id_exp_code!=0: pass the code through; mem_op=NOP, ctrl_op=NOP, ex_gpr_we_=1. Upstream exception wins over overflow.
  - of=1: ex_exp_code=OVERFLOW; mem_op=NOP, ctrl_op=NOP, ex_gpr_we_=1. ex_out still holds the wrapped result.
  - otherwise: all fields latch their inputs; ex_exp_code=0.
- Latency: one cycle from ID inputs to ex_* outputs. No internal state beyond the EX/MEM register.

Test Plan:
- Reset: assert reset=0 mid-stream → all ex_* outputs 0 and ex_gpr_we_=1, immediately, without waiting for clk.
- ADDU: 0x0000_0005 + 0x0000_0003, en=1, dst=7, we_=0 → fwd_data=8 same cycle; next edge ex_out=8, ex_dst_addr=7, ex_gpr_we_=0, ex_exp_code=0.
- ADDS overflow: 0x7FFF_FFFF + 1, we_=0, mem_op=STW → ex_out=0x8000_0000, ex_exp_code=3, ex_gpr_we_=1, ex_mem_op=0.
  - SUBS 0x8000_0000 - 1 → same exception.
  - SUBU 0x8000_0000 - 1 → 0x7FFF_FFFF, no exception.
- Shifts: SHLL 0x1 by in_1=0x21 → ex_out=0x2 (5-bit amount). SHRL 0x8000_0000 by 31 → 0x1.
- stall then flush: latch AND 0xF0F0 & 0xFF00 = 0xF000.
  - stall=1 for 3 cycles with new inputs → outputs unchanged.
  - stall=1 and flush=1 → still held.
  - flush=1, stall=0 → bubble: ex_en=0, ex_gpr_we_=1.
- Upstream exception priority: id_exp_code=2 together with ADDS overflow → ex_exp_code=2, ex_gpr_we_=1.
